// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the command sequencer.
// Holds the FSM state enum, the command byte values and the fixed
// register-file addresses used for ALU operands.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_ALU_OPA  = 4'd5,
        ST_ALU_OPB  = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_RD    = 4'd9,
        ST_TX_HI    = 4'd10,
        ST_TX_LO    = 4'd11
    } state_e;

    // Frame header bytes
    localparam logic [7:0] CMD_RF_WR    = 8'hAA;
    localparam logic [7:0] CMD_RF_RD    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPR  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOPR = 8'hDD;

    // Register-file slots the ALU reads its operands from
    localparam int unsigned ADDR_OP_A = 0;
    localparam int unsigned ADDR_OP_B = 1;

    // True in the states that own the TX FIFO write port
    function automatic logic is_tx_state(state_e s);
        return (s == ST_TX_RD) || (s == ST_TX_HI) || (s == ST_TX_LO);
    endfunction

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: parses UART frames (AA wr, BB rd, CC alu+ops, DD alu) into RF/ALU strobes, pushes results to TX FIFO.
// Latency: strobes 1 cycle after the completing RX byte; RF_RD_VLD / ALU_OUT_VLD to first push 1 cycle.
// Backpressure: TX states hold their byte while FIFO_FULL=1 and push in the first non-full cycle; RX bytes are dropped while busy.
//
// Ports:
//   REF_CLK, RST              clock, async active-low reset
//   RX_P_DATA / RX_D_VLD      received byte + one-cycle valid pulse
//   RF_ADDR / RF_WR_EN / RF_RD_EN / RF_WR_DATA / RF_RD_DATA / RF_RD_VLD   register file
//   ALU_EN / ALU_FUN / ALU_OUT / ALU_OUT_VLD / CLK_GATE_EN               ALU and its clock gate
//   FIFO_WR_DATA / FIFO_WR_INC / FIFO_FULL                               TX FIFO write side
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    REF_CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
    output logic                    FIFO_WR_INC,
    input  logic                    FIFO_FULL
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]    fun_q, fun_d;
    logic                    gate_q, gate_d;
    // TX holding register: tx_byte_q is what the FIFO sees, tx_lo_q parks
    // the low half of an ALU result until the high byte has gone out.
    logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;
    logic [DATA_WIDTH-1:0]   tx_lo_q, tx_lo_d;
    logic                    push;

    // Push is combinational on FIFO_FULL so a TX state fires in the very
    // first non-full cycle and can never strobe into a full FIFO.
    assign push = is_tx_state(state_q) && !FIFO_FULL;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        fun_d     = fun_q;
        gate_d    = gate_q;
        tx_byte_d = tx_byte_q;
        tx_lo_d   = tx_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:    state_d = ST_WR_ADDR;
                        CMD_RF_RD:    state_d = ST_RD_ADDR;
                        CMD_ALU_OPR:  state_d = ST_ALU_OPA;
                        CMD_ALU_NOPR: state_d = ST_ALU_FUN;
                        default:      state_d = ST_IDLE;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (RF_RD_VLD) begin
                    tx_byte_d = RF_RD_DATA;
                    state_d   = ST_TX_RD;
                end
            end

            ST_ALU_OPA: begin
                if (RX_D_VLD) begin
                    addr_d    = ADDR_OP_A[ADDR_WIDTH-1:0];
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_OPB;
                end
            end

            ST_ALU_OPB: begin
                if (RX_D_VLD) begin
                    addr_d    = ADDR_OP_B[ADDR_WIDTH-1:0];
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_FUN;
                end
            end

            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    fun_d    = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d = 1'b1;
                    // Gate opens together with ALU_EN
                    gate_d   = 1'b1;
                    state_d  = ST_ALU_WAIT;
                end
            end

            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    tx_byte_d = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_lo_d   = ALU_OUT[DATA_WIDTH-1:0];
                    // Gate stays open through the capture cycle only
                    gate_d    = 1'b0;
                    state_d   = ST_TX_HI;
                end
            end

            ST_TX_RD: begin
                if (push) begin
                    state_d = ST_IDLE;
                end
            end

            ST_TX_HI: begin
                if (push) begin
                    tx_byte_d = tx_lo_q;
                    state_d   = ST_TX_LO;
                end
            end

            ST_TX_LO: begin
                if (push) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            fun_q     <= '0;
            gate_q    <= 1'b0;
            tx_byte_q <= '0;
            tx_lo_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            fun_q     <= fun_d;
            gate_q    <= gate_d;
            tx_byte_q <= tx_byte_d;
            tx_lo_q   <= tx_lo_d;
        end
    end

    assign RF_ADDR      = addr_q;
    assign RF_WR_EN     = wr_en_q;
    assign RF_RD_EN     = rd_en_q;
    assign RF_WR_DATA   = wr_data_q;
    assign ALU_EN       = alu_en_q;
    assign ALU_FUN      = fun_q;
    assign CLK_GATE_EN  = gate_q;
    assign FIFO_WR_DATA = tx_byte_q;
    assign FIFO_WR_INC  = push;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: directed frames with cycle-exact checks, then
// random frames compared against a transaction-level model of the protocol.
// Register file and ALU are behavioural stubs driven from the stimulus process.
module tb_sys_cmd_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic            REF_CLK = 1'b0;
    logic            RST = 1'b1;
    logic [DW-1:0]   RX_P_DATA;
    logic            RX_D_VLD;
    logic [AW-1:0]   RF_ADDR;
    logic            RF_WR_EN;
    logic            RF_RD_EN;
    logic [DW-1:0]   RF_WR_DATA;
    logic [DW-1:0]   RF_RD_DATA;
    logic            RF_RD_VLD;
    logic            ALU_EN;
    logic [FW-1:0]   ALU_FUN;
    logic [2*DW-1:0] ALU_OUT;
    logic            ALU_OUT_VLD;
    logic            CLK_GATE_EN;
    logic [DW-1:0]   FIFO_WR_DATA;
    logic            FIFO_WR_INC;
    logic            FIFO_FULL;

    always #5 REF_CLK = ~REF_CLK;

    sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
        .REF_CLK(REF_CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
        .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC), .FIFO_FULL(FIFO_FULL)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Observed transactions and model expectations
    logic [11:0] wr_log[$], exp_wr[$];
    logic [3:0]  rd_log[$], exp_rd[$];
    logic [3:0]  fun_log[$], exp_fun[$];
    logic [7:0]  tx_log[$], exp_tx[$];
    logic [7:0]  rf_mem[16];
    logic [7:0]  exp_rf[16];
    int full_viol = 0;
    int gate_viol = 0;

    // Outputs sampled in the most recent cycle
    logic       s_wr, s_rd, s_alu, s_inc, s_gate;
    logic [3:0] s_addr, s_fun;
    logic [7:0] s_wdata, s_fdata;

    // Stub state
    bit         rd_pend = 0;
    logic [3:0] rd_addr;
    int         alu_cnt = 0;
    int         alu_lat = 2;
    logic [3:0] alu_fun_s;
    bit         rand_full = 0;

    function automatic logic [15:0] alu_ref(logic [3:0] f, logic [7:0] a, logic [7:0] b);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            default: return {8'h00, a & b};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at posedge+1; samples this cycle at negedge, then drives the
    // next cycle's stub responses at the following posedge+1.
    task automatic tick();
        @(negedge REF_CLK);
        s_wr = RF_WR_EN; s_rd = RF_RD_EN; s_alu = ALU_EN; s_inc = FIFO_WR_INC;
        s_gate = CLK_GATE_EN; s_addr = RF_ADDR; s_fun = ALU_FUN;
        s_wdata = RF_WR_DATA; s_fdata = FIFO_WR_DATA;
        if (RF_WR_EN) begin
            wr_log.push_back({RF_ADDR, RF_WR_DATA});
            rf_mem[RF_ADDR] = RF_WR_DATA;
        end
        if (RF_RD_EN) begin
            rd_log.push_back(RF_ADDR);
            rd_pend = 1;
            rd_addr = RF_ADDR;
        end
        if (ALU_EN) begin
            fun_log.push_back(ALU_FUN);
            alu_cnt   = alu_lat;
            alu_fun_s = ALU_FUN;
            if (!CLK_GATE_EN) gate_viol++;
        end
        if (FIFO_WR_INC) begin
            tx_log.push_back(FIFO_WR_DATA);
            if (FIFO_FULL) full_viol++;
            if (CLK_GATE_EN) gate_viol++;
        end
        @(posedge REF_CLK);
        #1;
        RF_RD_VLD   = 0;
        RF_RD_DATA  = 8'($urandom);
        ALU_OUT_VLD = 0;
        ALU_OUT     = 16'($urandom);
        if (rd_pend) begin
            RF_RD_VLD  = 1;
            RF_RD_DATA = rf_mem[rd_addr];
            rd_pend    = 0;
        end
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                ALU_OUT_VLD = 1;
                ALU_OUT     = alu_ref(alu_fun_s, rf_mem[0], rf_mem[1]);
            end
        end
        if (rand_full) FIFO_FULL = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_byte(logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1;
        tick();
        RX_D_VLD  = 0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic gap_send(logic [7:0] b);
        repeat ($urandom_range(0, 1)) tick();
        send_byte(b);
    endtask

    task automatic wait_push(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_inc) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 300 && tx_log.size() < exp_tx.size(); i++) tick();
        chk("tx_drain", tx_log.size(), exp_tx.size());
    endtask

    // Transaction-level model
    task automatic m_write(logic [7:0] a, logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        exp_rf[a[3:0]] = d;
    endtask

    task automatic m_read(logic [7:0] a);
        exp_rd.push_back(a[3:0]);
        exp_tx.push_back(exp_rf[a[3:0]]);
    endtask

    task automatic m_alu(logic [7:0] f);
        logic [15:0] r;
        r = alu_ref(f[3:0], exp_rf[0], exp_rf[1]);
        exp_fun.push_back(f[3:0]);
        exp_tx.push_back(r[15:8]);
        exp_tx.push_back(r[7:0]);
    endtask

    task automatic chk_reset_outputs(string pfx);
        chk({pfx, "_wr_en"}, RF_WR_EN, 0);
        chk({pfx, "_rd_en"}, RF_RD_EN, 0);
        chk({pfx, "_alu_en"}, ALU_EN, 0);
        chk({pfx, "_inc"}, FIFO_WR_INC, 0);
        chk({pfx, "_gate"}, CLK_GATE_EN, 0);
        chk({pfx, "_addr"}, RF_ADDR, 0);
        chk({pfx, "_wdata"}, RF_WR_DATA, 0);
        chk({pfx, "_fdata"}, FIFO_WR_DATA, 0);
        chk({pfx, "_fun"}, ALU_FUN, 0);
    endtask

    initial begin
        bit ok;
        int cnt, n_wr;
        logic [7:0] a, b, d, f;

        RX_P_DATA = 0; RX_D_VLD = 0; RF_RD_DATA = 0; RF_RD_VLD = 0;
        ALU_OUT = 0; ALU_OUT_VLD = 0; FIFO_FULL = 0;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = 0;
            exp_rf[i] = 0;
        end
        #3 RST = 0;
        repeat (3) @(posedge REF_CLK);
        #1;
        chk_reset_outputs("reset");
        RST = 1;
        tick();

        // Write AA,05,A6
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'hA6);
        m_write(8'h05, 8'hA6);
        tick();
        chk("wr_en", s_wr, 1);
        chk("wr_addr", s_addr, 4'h5);
        chk("wr_data", s_wdata, 8'hA6);
        tick();
        chk("wr_en_one_cycle", s_wr, 0);

        // Read BB,05 -> push A6
        send_byte(8'hBB); send_byte(8'h05);
        m_read(8'h05);
        tick();
        chk("rd_en", s_rd, 1);
        chk("rd_addr", s_addr, 4'h5);
        tick();
        chk("rd_no_early_push", s_inc, 0);
        tick();
        chk("rd_push", s_inc, 1);
        chk("rd_push_data", s_fdata, 8'hA6);
        tick();
        chk("rd_single_push", s_inc, 0);

        // ALU with operands CC,28,1E,01 -> 0x000A; junk AA while waiting
        alu_lat = 3;
        send_byte(8'hCC); send_byte(8'h28); send_byte(8'h1E);
        chk("opa_wr", {s_wr, s_addr, s_wdata}, {1'b1, 4'h0, 8'h28});
        send_byte(8'h01);
        chk("opb_wr", {s_wr, s_addr, s_wdata}, {1'b1, 4'h1, 8'h1E});
        chk("gate_before_en", s_gate, 0);
        m_write(8'h00, 8'h28); m_write(8'h01, 8'h1E); m_alu(8'h01);
        send_byte(8'hAA);
        chk("alu_en", s_alu, 1);
        chk("alu_fun", s_fun, 4'h1);
        chk("gate_at_en", s_gate, 1);
        tick();
        chk("alu_en_one_cycle", s_alu, 0);
        chk("gate_wait", s_gate, 1);
        wait_push(ok);
        chk("alu_push_seen", ok, 1);
        chk("alu_hi", s_fdata, 8'h00);
        chk("alu_fun_held", s_fun, 4'h1);
        chk("gate_off_tx", s_gate, 0);
        tick();
        chk("alu_lo_push", s_inc, 1);
        chk("alu_lo", s_fdata, 8'h0A);
        tick();
        chk("alu_tx_done", s_inc, 0);

        // ALU without operands DD,00 -> 0x0046, FIFO full 5 cycles in TX_HI
        alu_lat = 2;
        n_wr = wr_log.size();
        FIFO_FULL = 1;
        send_byte(8'hDD); send_byte(8'h00);
        m_alu(8'h00);
        tick();
        chk("nopr_alu_en", s_alu, 1);
        chk("nopr_fun", s_fun, 4'h0);
        cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            cnt += int'(s_inc);
            if (k == 2) chk("nopr_gate_capture", s_gate, 1);
            if (k == 3) chk("nopr_gate_after", s_gate, 0);
        end
        chk("no_push_while_full", cnt, 0);
        FIFO_FULL = 0;
        tick();
        chk("bp_hi_push", {s_inc, s_fdata}, {1'b1, 8'h00});
        tick();
        chk("bp_lo_push", {s_inc, s_fdata}, {1'b1, 8'h46});
        tick();
        chk("bp_done", s_inc, 0);
        chk("nopr_no_rf_wr", wr_log.size(), n_wr);

        // Unknown command, then write AA,03,7C
        send_byte(8'h55);
        cnt = 0;
        repeat (3) begin
            tick();
            cnt += int'(s_wr | s_rd | s_alu | s_inc);
        end
        chk("unknown_quiet", cnt, 0);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h7C);
        m_write(8'h03, 8'h7C);
        tick();
        chk("after_unknown_wr", {s_wr, s_addr, s_wdata}, {1'b1, 4'h3, 8'h7C});

        // Reset mid-frame after AA,05
        send_byte(8'hAA); send_byte(8'h05);
        n_wr = wr_log.size();
        RST = 0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge REF_CLK);
        #1;
        RST = 1;
        send_byte(8'hBB); send_byte(8'h05);
        m_read(8'h05);
        tick();
        chk("post_rst_rd", {s_rd, s_addr}, {1'b1, 4'h5});
        wait_push(ok);
        chk("post_rst_push_seen", ok, 1);
        chk("post_rst_data", s_fdata, 8'hA6);
        chk("post_rst_no_wr", wr_log.size(), n_wr);
        tick();

        // Random frames under random backpressure
        rand_full = 1;
        for (int fr = 0; fr < 40; fr++) begin
            a = 8'($urandom); b = 8'($urandom); d = 8'($urandom); f = 8'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    gap_send(8'hAA); gap_send(a); gap_send(d);
                    m_write(a, d);
                end
                1: begin
                    gap_send(8'hBB); gap_send(a);
                    m_read(a);
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
                    wait_tx();
                end
                2: begin
                    alu_lat = $urandom_range(1, 4);
                    f = 8'($urandom_range(0, 5));
                    gap_send(8'hCC); gap_send(a); gap_send(b); gap_send(f);
                    m_write(8'h00, a); m_write(8'h01, b); m_alu(f);
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
                    wait_tx();
                end
                3: begin
                    alu_lat = $urandom_range(1, 4);
                    gap_send(8'hDD); gap_send(f);
                    m_alu(f);
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
                    wait_tx();
                end
                default: begin
                    do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    gap_send(b);
                end
            endcase
        end
        rand_full = 0;
        FIFO_FULL = 0;
        repeat (5) tick();

        chk("wr_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk($sformatf("wr[%0d]", i), wr_log[i], exp_wr[i]);
        chk("rd_count", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk($sformatf("rd[%0d]", i), rd_log[i], exp_rd[i]);
        chk("alu_count", fun_log.size(), exp_fun.size());
        for (int i = 0; i < exp_fun.size() && i < fun_log.size(); i++)
            chk($sformatf("fun[%0d]", i), fun_log[i], exp_fun[i]);
        chk("tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk($sformatf("tx[%0d]", i), tx_log[i], exp_tx[i]);
        chk("push_while_full", full_viol, 0);
        chk("gate_violations", gate_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command sequencer between the UART receive path and the register file / ALU datapath, running in the reference clock domain. It parses the framed command stream (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) and drives register-file and ALU strobes. Results are pushed byte-by-byte into the TX async FIFO.

## Interface
- DATA_WIDTH, 8: byte width of RX/TX/register data.
- ADDR_WIDTH, 4: register-file address width; the address byte is truncated to its low ADDR_WIDTH bits.
- FUN_WIDTH, 4: ALU function width; the function byte is truncated to its low FUN_WIDTH bits.

Ports:
- REF_CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_P_DATA  in  DATA_WIDTH  synchronized received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid in this cycle.
- RF_ADDR  out  ADDR_WIDTH  register-file address.
- RF_WR_EN  out  1  one-cycle write strobe.
- RF_RD_EN  out  1  one-cycle read strobe.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- RF_RD_DATA  in  DATA_WIDTH  read data.
- RF_RD_VLD  in  1  read data valid pulse.
- ALU_EN  out  1  one-cycle operation strobe.
- ALU_FUN  out  FUN_WIDTH  ALU function, held stable from ALU_EN until ALU_OUT_VLD.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  result valid pulse.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- FIFO_WR_DATA  out  DATA_WIDTH  byte for TX FIFO.
- FIFO_WR_INC  out  1  one-cycle push strobe.
- FIFO_FULL  in  1  TX FIFO full; a push must not be issued while it is high.

## Operation
- Registered Moore FSM. States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_RD, TX_HI, TX_LO.
- IDLE: on RX_D_VLD, dispatch on the command byte.
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to ALU_OPA.
  - 0xDD goes to ALU_FUN.
  - Any other byte is dropped and the FSM stays in IDLE.
- Write sequence:
  - WR_ADDR: latch the address, go to WR_DATA.
  - WR_DATA: on the byte, issue RF_WR_EN with RF_ADDR/RF_WR_DATA, then return to IDLE.
- Read sequence:
  - RD_ADDR: on the byte, issue RF_RD_EN, go to RD_WAIT.
  - RD_WAIT: on RF_RD_VLD, capture RF_RD_DATA and go to TX_RD.
  - TX_RD: push the captured byte, then return to IDLE.
- ALU with operands:
  - ALU_OPA: write the byte to RF address 0, go to ALU_OPB.
  - ALU_OPB: write the byte to RF address 1, go to ALU_FUN.
- ALU_FUN: on the byte, latch the function, issue ALU_EN, go to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT, then go to TX_HI.
- Result transmission:
  - TX_HI pushes ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] first.
  - TX_LO then pushes the low byte and returns to IDLE.
- CLK_GATE_EN:
  - Asserted from the cycle ALU_EN is issued through the ALU_OUT_VLD capture cycle.
  - Low otherwise, including in IDLE.
- Any TX state holds its data while FIFO_FULL=1. It pushes in the first cycle FIFO_FULL=0.
- RX_D_VLD pulses are ignored in RD_WAIT, ALU_WAIT and the TX states; no buffering.

## Timing
- Reset values:
  - All strobes (RF_WR_EN, RF_RD_EN, ALU_EN, FIFO_WR_INC) and CLK_GATE_EN are 0.
  - RF_ADDR, RF_WR_DATA, FIFO_WR_DATA and ALU_FUN are 0.
  - The FSM is in IDLE.
- Register strobes and ALU_EN assert in the cycle after the RX_D_VLD that completes the frame. They are high for exactly one cycle.
- RF_ADDR and RF_WR_DATA are valid in the same cycle as their strobe.
- Read latency: RF_RD_VLD to FIFO_WR_INC is 1 cycle when FIFO_FULL=0.
- ALU result latency: ALU_OUT_VLD to the high-byte push is 1 cycle. The low-byte push follows 1 cycle later when the FIFO is not full.
- FIFO_WR_INC is never high while FIFO_FULL is high in the same cycle.
- Reset asserted mid-sequence aborts the sequence immediately:
  - No partial write is issued.
  - No TX byte is issued.
  - Captured data is discarded.
- RX_D_VLD on back-to-back cycles: each pulse is consumed in sequence.

## Structure
- Package sys_ctrl_pkg holds:
  - the state enum;
  - command constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OPR=8'hCC, CMD_ALU_NOPR=8'hDD;
  - operand addresses ADDR_OP_A=0 and ADDR_OP_B=1.
- Single module, no sub-modules. A small TX byte-holding register is inline.

## Test plan
- Write then read:
  - Stimulus: AA,05,A6, then BB,05, with RF model returning A6.
  - Response: one RF_WR_EN with addr 5 / data A6; RF_RD_EN at addr 5; a single FIFO push of 0xA6.
- ALU with operands:
  - Stimulus: CC,28,1E,01; ALU returns 0x000A.
  - Response: writes 0x28→addr0 and 0x1E→addr1; ALU_FUN=1; pushes 0x00 then 0x0A.
- ALU without operands:
  - Stimulus: DD,00; ALU returns 0x0046.
  - Response: no RF writes; pushes 0x00 then 0x46; CLK_GATE_EN low before ALU_EN and after capture.
- FIFO backpressure:
  - Stimulus: FIFO_FULL held high for 5 cycles during TX_HI.
  - Response: no push while full; 0x00 pushed in the first non-full cycle; 0x46 pushed next; no byte lost.
- Unknown command and ignored bytes:
  - Stimulus: 0x55, then AA,03,7C.
  - Response: 0x55 causes no activity; the write to addr 3 occurs.
  - Stimulus: a byte sent during ALU_WAIT.
  - Response: the byte is ignored.
- Reset mid-frame:
  - Stimulus: RST low after AA,05.
  - Response: all outputs at reset values.
  - Stimulus: subsequent BB,05.
  - Response: processed normally, with no stale write.
